// File: rtl/segasys1_sndcmd_queue_if.sv
// Sound-command bus: main-CPU push side, sound-CPU latch/NMI side.
// Latency: none (plain wires).
// Backpressure: none; the queue reports lost pushes on OVF.
interface segasys1_sndcmd_queue_if;
  logic       SNDRQ;
  logic [7:0] SNDNO;
  logic       SRD;
  logic [7:0] SDO;
  logic       SVALID;
  logic       SNMI;
  logic       OVF;

  // CPU-side view: drives requests and latch reads, observes queue state.
  modport master (
    output SNDRQ, SNDNO, SRD,
    input  SDO, SVALID, SNMI, OVF
  );

  // Queue-side view.
  modport slave (
    input  SNDRQ, SNDNO, SRD,
    output SDO, SVALID, SNMI, OVF
  );
endinterface

// File: rtl/segasys1_sndcmd_queue.sv
// Purpose: FIFO of main-CPU sound commands with NMI pulse/retry towards the sound CPU.
// Latency: push at edge N -> SDO/SVALID after N+1, SNMI high from N+2 for NMI_CYC cycles.
// Backpressure: none; a push into a full queue is dropped (or overwrites the newest
// entry when SNDCMDQ_LOSSLESS_EN is defined) and sets sticky OVF.
module segasys1_sndcmd_queue #(
  parameter int DEPTH   = 4,
  parameter int NMI_CYC = 96,
  parameter int TMO_CYC = 48000
) (
  input  logic                   CLK48M,
  input  logic                   RESET_N,
  segasys1_sndcmd_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = (NMI_CYC > 1) ? $clog2(NMI_CYC) : 1;
  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [NW-1:0] NMI_LOAD = NW'(NMI_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_ACK = 2'd2
  } nmi_state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          srd_q;

  // Registered outputs
  logic [7:0]    sdo_r;
  logic          svalid_r;
  logic          ovf_r;
  logic          snmi_r;

  // NMI sequencer
  nmi_state_t    state;
  nmi_state_t    state_nxt;
  logic [NW-1:0] nmi_cnt;
  logic [NW-1:0] nmi_cnt_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_cnt_nxt;
  logic          ack;
  logic          ack_nxt;
  logic          snmi_nxt;

  logic          pop;
  logic          full;
  logic          push_ok;
  logic          push_full;

  // A held SRD level pops once: only its rising edge counts, and only when the
  // sound CPU can see a valid byte.
  assign pop       = bus.SRD & ~srd_q & svalid_r;
  assign full      = (count == FULL_CNT);
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push_ok   = bus.SNDRQ & (~full | pop);
  assign push_full = bus.SNDRQ & full & ~pop;

  // Command storage; contents need no reset since SDO only reads live entries.
  always_ff @(posedge CLK48M) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.SNDNO;
    end
`ifdef SNDCMDQ_LOSSLESS_EN
    else if (push_full) begin
      // Replace the newest entry so the latest command is never lost.
      mem[wr_ptr - PW'(1)] <= bus.SNDNO;
    end
`endif
  end

  // Pointers, occupancy, overflow flag and the registered head-of-queue view.
  always_ff @(posedge CLK48M) begin
    if (!RESET_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      srd_q    <= 1'b0;
      ovf_r    <= 1'b0;
      svalid_r <= 1'b0;
      sdo_r    <= 8'h00;
    end else begin
      srd_q <= bus.SRD;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_full) begin
        ovf_r <= 1'b1;
      end
      // The view trails the FIFO by one edge; when the queue drains SDO keeps
      // the last byte that was handed out.
      svalid_r <= (count != '0);
      if (count != '0) begin
        sdo_r <= mem[rd_ptr];
      end
    end
  end

  // NMI sequencer state register.
  always_ff @(posedge CLK48M) begin
    if (!RESET_N) begin
      state   <= IDLE;
      nmi_cnt <= '0;
      tmo_cnt <= '0;
      ack     <= 1'b0;
      snmi_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      nmi_cnt <= nmi_cnt_nxt;
      tmo_cnt <= tmo_cnt_nxt;
      ack     <= ack_nxt;
      snmi_r  <= snmi_nxt;
    end
  end

  // NMI sequencer next-state: pulse on pending data, wait for the latch read,
  // re-pulse on timeout.
  always_comb begin
    state_nxt   = state;
    nmi_cnt_nxt = nmi_cnt;
    tmo_cnt_nxt = tmo_cnt;
    ack_nxt     = ack;
    snmi_nxt    = snmi_r;
    unique case (state)
      IDLE: begin
        // SVALID lags count by an edge; the count term stops a stale SVALID
        // right after the final pop from starting a pulse for an empty queue.
        if (svalid_r && (count != '0)) begin
          state_nxt   = PULSE;
          snmi_nxt    = 1'b1;
          nmi_cnt_nxt = NMI_LOAD;
          ack_nxt     = 1'b0;
        end
      end
      PULSE: begin
        if (nmi_cnt == '0) begin
          // Full width always served; an early read skips the wait state.
          snmi_nxt    = 1'b0;
          tmo_cnt_nxt = '0;
          ack_nxt     = 1'b0;
          state_nxt   = (ack || pop) ? IDLE : WAIT_ACK;
        end else begin
          nmi_cnt_nxt = nmi_cnt - NW'(1);
          if (pop) begin
            ack_nxt = 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        if (pop) begin
          state_nxt = IDLE;
        end else if (TMO_CYC != 0) begin
          if (tmo_cnt == TMO_LAST) begin
            state_nxt   = PULSE;
            snmi_nxt    = 1'b1;
            nmi_cnt_nxt = NMI_LOAD;
            ack_nxt     = 1'b0;
          end else begin
            tmo_cnt_nxt = tmo_cnt + TW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        snmi_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.SDO    = sdo_r;
  assign bus.SVALID = svalid_r;
  assign bus.SNMI   = snmi_r;
  assign bus.OVF    = ovf_r;

endmodule

// File: tb/tb_segasys1_sndcmd_queue.sv
// Directed bench for segasys1_sndcmd_queue with a byte scoreboard.
// Runs with DEPTH=4, NMI_CYC=96, TMO_CYC=200.
// Expectations adapt to SNDCMDQ_LOSSLESS_EN when it is defined.
module tb_segasys1_sndcmd_queue;
  localparam int DEPTH   = 4;
  localparam int NMI_CYC = 96;
  localparam int TMO_CYC = 200;

  logic CLK48M = 1'b0;
  logic RESET_N;

  segasys1_sndcmd_queue_if bus ();

  segasys1_sndcmd_queue #(
    .DEPTH  (DEPTH),
    .NMI_CYC(NMI_CYC),
    .TMO_CYC(TMO_CYC)
  ) dut (
    .CLK48M (CLK48M),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  always #5 CLK48M = ~CLK48M;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  logic       exp_ovf  = 1'b0;
  logic [7:0] last_pop = 8'h00;

  task automatic tick();
    @(posedge CLK48M);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RESET_N    = 1'b0;
    bus.SNDRQ  = 1'b0;
    bus.SRD    = 1'b0;
    bus.SNDNO  = 8'h00;
    tick();
    tick();
    RESET_N = 1'b1;
    sb.delete();
    exp_ovf = 1'b0;
    tick();
  endtask

  // One-cycle push; the scoreboard models drop-new or overwrite-newest.
  task automatic push(input logic [7:0] b);
    bus.SNDRQ = 1'b1;
    bus.SNDNO = b;
    if (sb.size() < DEPTH) begin
      sb.push_back(b);
    end else begin
      exp_ovf = 1'b1;
`ifdef SNDCMDQ_LOSSLESS_EN
      sb[sb.size() - 1] = b;
`endif
    end
    tick();
    bus.SNDRQ = 1'b0;
  endtask

  // Compare the presented head with the scoreboard, then read it with a
  // 3-cycle SRD level.
  task automatic pop_check(input string tag);
    logic [7:0] e;
    int w;
    w = 0;
    while (!bus.SVALID && w < 400) begin
      tick();
      w++;
    end
    check({tag, "_vld"}, bus.SVALID, 1);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed pop expected none (scoreboard empty)", tag);
    end else begin
      e = sb.pop_front();
      last_pop = e;
      check(tag, bus.SDO, e);
      bus.SRD = 1'b1;
      repeat (3) tick();
      bus.SRD = 1'b0;
      repeat (2) tick();
    end
  endtask

  initial begin
    int hi;
    int k;
    int w;
    logic nmi_seen;
    logic [7:0] e;

    RESET_N   = 1'b0;
    bus.SNDRQ = 1'b0;
    bus.SNDNO = 8'h00;
    bus.SRD   = 1'b0;

    // Reset state
    tick();
    check("rst_sdo", bus.SDO, 8'h00);
    check("rst_svalid", bus.SVALID, 0);
    check("rst_snmi", bus.SNMI, 0);
    check("rst_ovf", bus.OVF, 0);
    do_reset();

    // Single push: view after N+1, NMI from N+2, width NMI_CYC
    push(8'h5A);
    check("t1_svalid_n", bus.SVALID, 0);
    tick();
    check("t1_svalid_n1", bus.SVALID, 1);
    check("t1_sdo_n1", bus.SDO, sb[0]);
    check("t1_snmi_n1", bus.SNMI, 0);
    tick();
    check("t1_snmi_n2", bus.SNMI, 1);
    hi = 0;
    while (bus.SNMI && hi < 300) begin
      hi++;
      tick();
    end
    check("t1_nmi_width", hi, NMI_CYC);

    // Held SRD in WAIT_ACK pops once; queue drains, NMI stays low
    e = sb.pop_front();
    check("t2_head", bus.SDO, e);
    nmi_seen = 1'b0;
    bus.SRD = 1'b1;
    repeat (8) begin
      tick();
      nmi_seen |= bus.SNMI;
    end
    bus.SRD = 1'b0;
    repeat (3) begin
      tick();
      nmi_seen |= bus.SNMI;
    end
    check("t2_svalid", bus.SVALID, 0);
    check("t2_snmi", nmi_seen, 0);
    check("t2_sdo_hold", bus.SDO, e);

    // Burst of five into a four-deep queue
    for (int i = 1; i <= 5; i++) push(8'(i));
    check("t3_ovf", bus.OVF, exp_ovf);
    pop_check("t3_pop0");
    pop_check("t3_pop1");
    pop_check("t3_pop2");
    pop_check("t3_pop3");
    tick();
    check("t3_empty", bus.SVALID, 0);
    check("t3_sdo_last", bus.SDO, last_pop);
    check("t3_ovf_sticky", bus.OVF, 1);

    // Full queue: push and pop in the same cycle
    do_reset();
    push(8'hA0);
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    tick();
    tick();
    check("t4_head", bus.SDO, sb[0]);
    bus.SNDRQ = 1'b1;
    bus.SNDNO = 8'h77;
    bus.SRD   = 1'b1;
    last_pop  = sb.pop_front();
    sb.push_back(8'h77);
    tick();
    bus.SNDRQ = 1'b0;
    tick();
    bus.SRD = 1'b0;
    tick();
    check("t4_ovf", bus.OVF, exp_ovf);
    check("t4_svalid", bus.SVALID, 1);
    pop_check("t4_pop0");
    pop_check("t4_pop1");
    pop_check("t4_pop2");
    pop_check("t4_pop3");
    tick();
    check("t4_empty", bus.SVALID, 0);

    // Retry: no read, second pulse TMO_CYC cycles after the first falls
    do_reset();
    push(8'h3C);
    w = 0;
    while (!bus.SNMI && w < 20) begin
      tick();
      w++;
    end
    check("t5_rise1", bus.SNMI, 1);
    w = 0;
    while (bus.SNMI && w < 200) begin
      tick();
      w++;
    end
    check("t5_fall1", bus.SNMI, 0);
    k = 0;
    while (!bus.SNMI && k < 400) begin
      tick();
      k++;
    end
    check("t5_retry_gap", k, TMO_CYC);

    // Reset in the middle of a pulse with three entries queued
    push(8'h11);
    push(8'h22);
    repeat (5) tick();
    check("t6_pre_snmi", bus.SNMI, 1);
    check("t6_pre_svalid", bus.SVALID, 1);
    RESET_N = 1'b0;
    tick();
    check("t6_snmi", bus.SNMI, 0);
    check("t6_svalid", bus.SVALID, 0);
    check("t6_sdo", bus.SDO, 8'h00);
    check("t6_ovf", bus.OVF, 0);
    RESET_N = 1'b1;
    sb.delete();
    nmi_seen = 1'b0;
    repeat (10) begin
      tick();
      nmi_seen |= bus.SNMI;
    end
    check("t6_post_svalid", bus.SVALID, 0);
    check("t6_post_snmi", nmi_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
